// File: rtl/mem_access_ctrl_if.sv
// Request/strobe bundle between the datapath control and the memory
// access controller. The master drives requests; the slave (controller)
// drives the address mux select, the write strobes and the done pulses.
interface mem_access_ctrl_if;
    logic       fetch_req;
    logic       data_req;
    logic       data_we;
    logic       exc_req;
    logic [1:0] iord_sel;
    logic       mem_wr;
    logic       ir_wr;
    logic       mdr_wr;
    logic       fetch_done;
    logic       data_done;
    logic       exc_done;
    logic       busy;

    modport master (
        output fetch_req, data_req, data_we, exc_req,
        input  iord_sel, mem_wr, ir_wr, mdr_wr,
        input  fetch_done, data_done, exc_done, busy
    );

    modport slave (
        input  fetch_req, data_req, data_we, exc_req,
        output iord_sel, mem_wr, ir_wr, mdr_wr,
        output fetch_done, data_done, exc_done, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch / load-store / exception-vector
// reads onto a single memory port. IDLE -> ACCESS (WAIT_CYCLES+1 cycles) ->
// TURN (one turnaround cycle) -> IDLE. All outputs come straight from flops.
// Optional feature: define IORD_EXC_VECTOR_EN to enable the exception-vector
// read path (highest priority, iord_sel = 2'b10). Without it exc_req is
// ignored and exc_done stays 0.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1  // memory read latency, 1..3
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);
    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_EXC  = 2'b10;
    localparam logic [1:0] CNT_INIT = 2'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] iord_sel_q, iord_sel_d;
    logic       we_q, we_d;
    logic       mem_wr_q, mem_wr_d;
    logic       ir_wr_q, ir_wr_d;
    logic       mdr_wr_q, mdr_wr_d;
    logic       fetch_done_q, fetch_done_d;
    logic       data_done_q, data_done_d;
    logic       exc_done_q, exc_done_d;
    logic       busy_q, busy_d;
    logic       exc_req_eff;

`ifdef IORD_EXC_VECTOR_EN
    assign exc_req_eff = bus.exc_req;
`else
    // Port is kept so both builds share one port list; the request is dropped.
    logic unused_exc_req;
    assign unused_exc_req = bus.exc_req;
    assign exc_req_eff    = 1'b0;
`endif

    // Next-state and next-output logic; strobes are set one cycle ahead
    // (when the counter is about to reach 0) so they come out of flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        iord_sel_d   = iord_sel_q;
        we_d         = we_q;
        mem_wr_d     = 1'b0;
        ir_wr_d      = 1'b0;
        mdr_wr_d     = 1'b0;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        exc_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                iord_sel_d = SEL_PC;
                if (exc_req_eff || bus.data_req || bus.fetch_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    we_d    = bus.data_we;
                    if (exc_req_eff)       iord_sel_d = SEL_EXC;
                    else if (bus.data_req) iord_sel_d = SEL_ALU;
                    else                   iord_sel_d = SEL_PC;
                end
            end

            ACCESS: begin
                cnt_d = cnt_q - 2'd1;
                // Next cycle is the final one: arm exactly one strobe + done.
                if (cnt_q == 2'd1) begin
                    case (iord_sel_q)
                        SEL_PC: begin
                            ir_wr_d      = 1'b1;
                            fetch_done_d = 1'b1;
                        end
                        SEL_ALU: begin
                            mem_wr_d    = we_q;
                            mdr_wr_d    = ~we_q;
                            data_done_d = 1'b1;
                        end
                        SEL_EXC: begin
                            mdr_wr_d   = 1'b1;
`ifdef IORD_EXC_VECTOR_EN
                            exc_done_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                if (cnt_q == 2'd0) begin
                    state_d    = TURN;
                    cnt_d      = 2'd0;
                    iord_sel_d = SEL_PC;
                end
            end

            TURN: begin
                state_d    = IDLE;
                iord_sel_d = SEL_PC;
            end

            default: begin
                state_d    = IDLE;
                iord_sel_d = SEL_PC;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset wins over any pending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            iord_sel_q   <= SEL_PC;
            we_q         <= 1'b0;
            mem_wr_q     <= 1'b0;
            ir_wr_q      <= 1'b0;
            mdr_wr_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            exc_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            iord_sel_q   <= iord_sel_d;
            we_q         <= we_d;
            mem_wr_q     <= mem_wr_d;
            ir_wr_q      <= ir_wr_d;
            mdr_wr_q     <= mdr_wr_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
            exc_done_q   <= exc_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.iord_sel   = iord_sel_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.ir_wr      = ir_wr_q;
    assign bus.mdr_wr     = mdr_wr_q;
    assign bus.fetch_done = fetch_done_q;
    assign bus.data_done  = data_done_q;
    assign bus.exc_done   = exc_done_q;
    assign bus.busy       = busy_q;
endmodule
